gem_cluster_packer: RTL and testbench

Upstream feeder for the fixed-latency trigger fiber transmitter. Accepts up to eight S-bit clusters per bunch crossing from the cluster finder, compacts them into a cluster queue, and presents four clusters per 25 ns frame as the 56-bit GEM data word plus a one-bit overflow flag. These are held stable for both 80 MHz halves of the frame the transmitter serializes. Clusters that cannot be queued are dropped, counted, and flagged on the next frame.

---
 rtl/gem_cluster_packer.sv | 139 +++++++++++++
 tb/tb_gem_cluster_packer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gem_cluster_packer.sv
// Cluster compactor and frame packer for the GEM trigger fiber link.
// Queues up to eight clusters per strobe and emits four clusters per two-cycle frame.
module gem_cluster_packer #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [13:0] EMPTY_WORD = 14'h3FFF
) (
  input  logic                          TRG_CLK80,
  input  logic                          TRG_RST_N,
  input  logic                          BX0_SYNC,
  input  logic                          CLUSTER_STB,
  input  logic [7:0]                    CLUSTER_VLD,
  input  logic [111:0]                  CLUSTERS,
  input  logic                          CLUSTER_OVF,
  output logic [55:0]                   GEM_DATA,
  output logic                          GEM_OVERFLOW,
  output logic                          FRAME_PHASE,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_CNT,
  output logic [15:0]                   DROP_CNT
);

  localparam int unsigned CW    = 14;
  localparam int unsigned NIN   = 8;
  localparam int unsigned NOUT  = 4;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic PH_FIRST = 1'b0;
  localparam logic PH_LOAD  = 1'b1;

  logic [CW-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [55:0]      data_q, data_d;
  logic [15:0]      drop_q, drop_d;

  logic [CW-1:0]    comp [NIN];
  logic [3:0]       n_valid;
  logic [3:0]       n_acc;
  logic [3:0]       n_drop;
  logic [2:0]       n_pop;
  logic [CNT_W-1:0] free_slots;
  logic             load;
  logic             ovf_cond;
  logic [16:0]      drop_sum;

  // Compact valid input slots toward index 0, preserving ascending slot order.
  always_comb begin
    n_valid = '0;
    for (int k = 0; k < NIN; k++) begin
      comp[k] = EMPTY_WORD;
    end
    if (CLUSTER_STB) begin
      for (int k = 0; k < NIN; k++) begin
        if (CLUSTER_VLD[k]) begin
          comp[n_valid[2:0]] = CLUSTERS[CW*k +: CW];
          n_valid            = n_valid + 4'd1;
        end
      end
    end
  end

  // Pop/push sizing; the pop frees room for a same-edge push.
  always_comb begin
    load  = (phase_q == PH_LOAD);
    n_pop = '0;
    if (load) begin
      n_pop = (cnt_q >= CNT_W'(NOUT)) ? 3'd4 : cnt_q[2:0];
    end
    free_slots = CNT_W'(FIFO_DEPTH) - cnt_q + CNT_W'(n_pop);
    n_acc      = (CNT_W'(n_valid) <= free_slots) ? n_valid : free_slots[3:0];
    n_drop     = n_valid - n_acc;
    ovf_cond   = (n_drop != 4'd0) || (CLUSTER_STB && CLUSTER_OVF);
    drop_sum   = {1'b0, drop_q} + 17'(n_drop);
  end

  always_comb begin
    phase_d  = (phase_q == PH_LOAD) ? PH_FIRST : PH_LOAD;
    rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_acc);
    cnt_d    = cnt_q - CNT_W'(n_pop) + CNT_W'(n_acc);
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    data_d   = data_q;
    ovf_d    = ovf_q;
    pend_d   = pend_q | ovf_cond;
    if (BX0_SYNC) begin
      phase_d = PH_FIRST;
    end
    // Frame load: head of queue only, same-edge pushes land behind it.
    if (load) begin
      for (int s = 0; s < NOUT; s++) begin
        data_d[CW*s +: CW] = (3'(s) < n_pop) ? mem_q[rd_ptr_q + PTR_W'(s)] : EMPTY_WORD;
      end
      ovf_d  = pend_q | ovf_cond;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge TRG_CLK80 or negedge TRG_RST_N) begin
    if (!TRG_RST_N) begin
      phase_q  <= PH_FIRST;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      data_q   <= {NOUT{EMPTY_WORD}};
      drop_q   <= '0;
    end else begin
      phase_q  <= phase_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
      drop_q   <= drop_d;
    end
  end

  // Queue storage needs no reset; pointers and count define its contents.
  always_ff @(posedge TRG_CLK80) begin
    for (int i = 0; i < NIN; i++) begin
      if (4'(i) < n_acc) begin
        mem_q[wr_ptr_q + PTR_W'(i)] <= comp[i];
      end
    end
  end

  assign GEM_DATA     = data_q;
  assign GEM_OVERFLOW = ovf_q;
  assign FRAME_PHASE  = phase_q;
  assign FIFO_CNT     = cnt_q;
  assign DROP_CNT     = drop_q;

endmodule

// File: tb/tb_gem_cluster_packer.sv
// Directed and randomized checks of gem_cluster_packer against a queue-based frame model.
module tb_gem_cluster_packer;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         bx0;
  logic         stb;
  logic [7:0]   vld;
  logic [111:0] cl;
  logic         covf;
  logic [55:0]  gem_data;
  logic         gem_ovf;
  logic         phase;
  logic [4:0]   fifo_cnt;
  logic [15:0]  drop_cnt;

  gem_cluster_packer #(.FIFO_DEPTH(DEPTH), .EMPTY_WORD(14'h3FFF)) dut (
    .TRG_CLK80   (clk),
    .TRG_RST_N   (rst_n),
    .BX0_SYNC    (bx0),
    .CLUSTER_STB (stb),
    .CLUSTER_VLD (vld),
    .CLUSTERS    (cl),
    .CLUSTER_OVF (covf),
    .GEM_DATA    (gem_data),
    .GEM_OVERFLOW(gem_ovf),
    .FRAME_PHASE (phase),
    .FIFO_CNT    (fifo_cnt),
    .DROP_CNT    (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [13:0] mq[$];
  logic        m_phase;
  logic [55:0] m_data;
  logic        m_ovf;
  logic        m_pend;
  int          m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 1'b0;
    m_data  = {4{14'h3FFF}};
    m_ovf   = 1'b0;
    m_pend  = 1'b0;
    m_drop  = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".data"},  64'(gem_data), 64'(m_data));
    chk({tag, ".ovf"},   64'(gem_ovf),  64'(m_ovf));
    chk({tag, ".phase"}, 64'(phase),    64'(m_phase));
    chk({tag, ".cnt"},   64'(fifo_cnt), 64'(mq.size()));
    chk({tag, ".drop"},  64'(drop_cnt), 64'(m_drop));
  endtask

  // One clock: drive inputs, advance the model by the frame rules, compare.
  task automatic step(input string tag, input logic s, input logic [7:0] v,
                      input logic [111:0] c, input logic o, input logic b);
    int npop;
    int nvalid;
    int nacc;
    logic cond;
    stb = s; vld = v; cl = c; covf = o; bx0 = b;
    @(posedge clk);
    npop = 0;
    if (m_phase) begin
      npop = (mq.size() < 4) ? mq.size() : 4;
      for (int k = 0; k < 4; k++) begin
        if (k < npop) m_data[14*k +: 14] = mq.pop_front();
        else          m_data[14*k +: 14] = 14'h3FFF;
      end
    end
    nvalid = 0;
    nacc   = 0;
    if (s) begin
      for (int k = 0; k < 8; k++) begin
        if (v[k]) begin
          nvalid++;
          if (mq.size() < DEPTH) begin
            mq.push_back(c[14*k +: 14]);
            nacc++;
          end
        end
      end
    end
    m_drop = (m_drop + nvalid - nacc > 65535) ? 65535 : m_drop + nvalid - nacc;
    cond = (nvalid != nacc) || (s && o);
    if (m_phase) begin
      m_ovf  = m_pend | cond;
      m_pend = 1'b0;
    end else begin
      m_pend = m_pend | cond;
    end
    m_phase = b ? 1'b0 : ~m_phase;
    #1;
    chk_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 8'h00, 112'd0, 1'b0, 1'b0);
  endtask

  // Bounded drain until the queue is empty and the next edge is phase 0.
  task automatic settle();
    for (int i = 0; i < 40 && (mq.size() != 0 || m_phase); i++) idle("settle");
    chk("settle.done", 64'(mq.size() != 0 || m_phase), 64'd0);
  endtask

  task automatic do_reset();
    stb = 1'b0; vld = '0; cl = '0; covf = 1'b0; bx0 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.data",  64'(gem_data), 64'h00FF_FFFF_FFFF_FFFF);
    chk("rst.ovf",   64'(gem_ovf),  64'd0);
    chk("rst.phase", 64'(phase),    64'd0);
    chk("rst.cnt",   64'(fifo_cnt), 64'd0);
    chk("rst.drop",  64'(drop_cnt), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [111:0] c8;
  logic [111:0] sp;
  logic [111:0] rc;

  initial begin
    rst_n = 1'b0;
    stb = 1'b0; vld = '0; cl = '0; covf = 1'b0; bx0 = 1'b0;
    model_reset();
    #12;
    do_reset();

    // Phase toggles after release
    idle("ph1"); chk("ph.seq1", 64'(phase), 64'd1);
    idle("ph2"); chk("ph.seq2", 64'(phase), 64'd0);

    // Sparse push
    settle();
    sp = '0;
    sp[13:0]  = 14'h011;
    sp[41:28] = 14'h033;
    sp[83:70] = 14'h022;
    step("sparse.push", 1'b1, 8'b0010_0101, sp, 1'b0, 1'b0);
    idle("sparse.load");
    chk("sparse.exp", 64'(gem_data), 64'({14'h3FFF, 14'h022, 14'h033, 14'h011}));
    chk("sparse.cnt", 64'(fifo_cnt), 64'd0);

    // Eight on one strobe
    settle();
    for (int k = 0; k < 8; k++) c8[14*k +: 14] = 14'(k + 1);
    step("eight.push", 1'b1, 8'hFF, c8, 1'b0, 1'b0);
    idle("eight.load1");
    chk("eight.f1", 64'(gem_data), 64'({14'd4, 14'd3, 14'd2, 14'd1}));
    idle("eight.gap");
    idle("eight.load2");
    chk("eight.f2", 64'(gem_data), 64'({14'd8, 14'd7, 14'd6, 14'd5}));
    chk("eight.ovf", 64'(gem_ovf), 64'd0);

    // Saturation
    settle();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) c8[14*k +: 14] = 14'(16 * r + k + 32);
      step("sat.push", 1'b1, 8'hFF, c8, 1'b0, 1'b0);
      chk("sat.cnt", 64'(fifo_cnt), (r == 0) ? 64'd8 : (r == 1) ? 64'd12 : 64'd16);
      if (r < 3) idle("sat.load");
    end
    chk("sat.drop", 64'(drop_cnt), 64'd4);
    idle("sat.load4");
    chk("sat.ovf1", 64'(gem_ovf), 64'd1);
    idle("sat.gap");
    idle("sat.load5");
    chk("sat.ovf0", 64'(gem_ovf), 64'd0);

    // Finder overflow with no valid clusters
    settle();
    step("covf.push", 1'b1, 8'h00, 112'd0, 1'b1, 1'b0);
    idle("covf.load1");
    chk("covf.data", 64'(gem_data), 64'h00FF_FFFF_FFFF_FFFF);
    chk("covf.ovf1", 64'(gem_ovf), 64'd1);
    idle("covf.gap");
    idle("covf.load2");
    chk("covf.ovf0", 64'(gem_ovf), 64'd0);

    // BX0 in phase 0 stretches, in phase 1 still loads
    settle();
    for (int k = 0; k < 8; k++) c8[14*k +: 14] = 14'(k + 100);
    step("bx0.p0", 1'b1, 8'hFF, c8, 1'b0, 1'b1);
    chk("bx0.stretch", 64'(phase), 64'd0);
    chk("bx0.noload", 64'(gem_data[13:0]), 64'h3FFF);
    idle("bx0.p0b");
    step("bx0.p1", 1'b0, 8'h00, 112'd0, 1'b0, 1'b1);
    chk("bx0.loaded", 64'(gem_data[13:0]), 64'd100);
    chk("bx0.realign", 64'(phase), 64'd0);

    // Randomized traffic with a mid-stream reset
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 8; k++) rc[14*k +: 14] = 14'($urandom);
      if (i == 200) do_reset();
      step("rand", ($urandom_range(0, 3) != 0), 8'($urandom), rc,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
